operand_regfile: RTL and testbench
==================================

// Module: operand_regfile
// PURPOSE
//  Register file and operand stage directly upstream of the function unit.
//  Reads two source registers (or a constant for B) into registered busA/busB.
//  Writes back the function-unit result F, or external data, into a destination register.
//  Latches the V/C/N/Z flags into a status register.
// PARAMETERS
//  DATA_W  32  word width; equals the busA/busB/F width
//  ADDR_W  5   register address width; 2**ADDR_W registers, R0 hardwired to zero
// PORTS
//  clk       in   1       single clock, rising edge
//  rst       in   1       synchronous, active-high reset
//  AA        in   ADDR_W  source-A register address
//  BA        in   ADDR_W  source-B register address
//  MB        in   1       1: busB takes const_in; 0: busB takes R[BA]
//  const_in  in   DATA_W  immediate operand
//  stall     in   1       1: hold busA/busB at current values
//  DA        in   ADDR_W  write-back destination address
//  RW        in   1       register-write enable
//  MD        in   1       write-back source; 0: F_in, 1: data_in
//  F_in      in   DATA_W  function-unit result F
//  data_in   in   DATA_W  external (memory) data
//  FL        in   1       flag-load enable
//  flags_in  in   4       {V,C,N,Z} from the function unit
//  busA      out  DATA_W  registered operand A to the function unit
//  busB      out  DATA_W  registered operand B to the function unit
//  status    out  4       registered {V,C,N,Z}
// BEHAVIOUR
//  - Reset, checked first in the clock block:
//    - all registers R0..R(2**ADDR_W-1) = 0; busA = 0; busB = 0; status = 0.
//    - RW/FL in a reset cycle are ignored.
//  - wb_data = MD ? data_in : F_in (combinational).
//  - Write-back, on a rising edge with rst=0:
//    - if RW and DA!=0, then R[DA] <= wb_data.
//    - RW with DA==0 is a no-op.
//  - Operand latency: 1 cycle. Addresses presented in cycle n appear on busA/busB after edge n.
//  - busA next value, when stall=0:
//    - AA==0 -> 0
//    - else RW && DA==AA -> wb_data (same-cycle bypass)
//    - else R[AA].
//  - busB next value, when stall=0:
//    - MB=1 -> const_in, regardless of BA
//    - else the same rule as busA using BA.
//  - stall=1:
//    - busA/busB hold their values; write-back and flag load still occur.
//    - Held operands are NOT refreshed by writes made during the stall; the controller re-issues.
//  - Flags: if FL, status <= flags_in; else hold. Independent of RW/stall.
//  - All arithmetic is pass-through; no width conversion. ADDR_W-bit addresses never go out of range.
//  - Simultaneous read and write of the same register: reads observe the new value via bypass.
// TESTING
//  1) rst=1 for 2 cycles -> busA=busB=status=0; reading R1..R31 afterwards gives 0.
//  2) RW=1,MD=0,DA=3,F_in=32'hDEADBEEF; next cycle AA=3 -> busA=32'hDEADBEEF after 1 edge.
//  3) Same edge: RW=1,DA=5,F_in=32'h12345678, AA=5, BA=5, MB=0 -> busA=busB=32'h12345678 (bypass).
//  4) RW=1,DA=0,F_in=32'hFFFFFFFF, then AA=0 -> busA=0; MB=1,const_in=32'h0000_00A5 -> busB=32'h000000A5.
//  5) stall=1 with busA=32'h11 while writing R[AA]=32'h22 -> busA stays 32'h11; stall=0 -> 32'h22.
//  6) FL=1,flags_in=4'b1010 -> status=4'b1010. FL=0,flags_in=4'b0101 -> status holds 4'b1010.
//     rst=1 mid-stream -> status=0.

Source files
------------

// File: rtl/operand_regfile.sv
// Register file and operand stage feeding the function unit: two bypassed read
// ports latched into busA/busB, one write-back port, and a {V,C,N,Z} status register.
module operand_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    input  logic              MB,
    input  logic [DATA_W-1:0] const_in,
    input  logic              stall,
    input  logic [ADDR_W-1:0] DA,
    input  logic              RW,
    input  logic              MD,
    input  logic [DATA_W-1:0] F_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              FL,
    input  logic [3:0]        flags_in,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic [3:0]        status
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] wb_data_c;
    logic              wr_en_c;
    logic [DATA_W-1:0] read_a_c;
    logic [DATA_W-1:0] read_b_c;

    assign wb_data_c = MD ? data_in : F_in;
    // Writes to R0 are discarded so it always reads as zero.
    assign wr_en_c   = RW && (DA != '0);

    // Read port A with same-cycle bypass of the write-back value.
    always_comb begin
        read_a_c = regs[AA];
        if (AA == '0) begin
            read_a_c = '0;
        end else if (wr_en_c && (DA == AA)) begin
            read_a_c = wb_data_c;
        end
    end

    // Read port B: immediate takes priority, otherwise same rule as port A.
    always_comb begin
        read_b_c = regs[BA];
        if (MB) begin
            read_b_c = const_in;
        end else if (BA == '0) begin
            read_b_c = '0;
        end else if (wr_en_c && (DA == BA)) begin
            read_b_c = wb_data_c;
        end
    end

    // Register array write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en_c) begin
            regs[DA] <= wb_data_c;
        end
    end

    // Operand latches; a stall freezes them even if their source is rewritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            busA <= '0;
            busB <= '0;
        end else if (!stall) begin
            busA <= read_a_c;
            busB <= read_b_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status <= '0;
        end else if (FL) begin
            status <= flags_in;
        end
    end

endmodule

// File: tb/tb_operand_regfile.sv
// Directed bench for operand_regfile: a per-cycle vector table with hand-computed
// operands/status, followed by a full write-then-read sweep of R1..R31.
module tb_operand_regfile;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] AA, BA, DA;
    logic              MB, stall, RW, MD, FL;
    logic [DATA_W-1:0] const_in, F_in, data_in;
    logic [3:0]        flags_in;
    logic [DATA_W-1:0] busA, busB;
    logic [3:0]        status;

    int checks = 0;
    int failures = 0;

    operand_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .AA(AA), .BA(BA), .MB(MB), .const_in(const_in),
        .stall(stall), .DA(DA), .RW(RW), .MD(MD), .F_in(F_in), .data_in(data_in),
        .FL(FL), .flags_in(flags_in), .busA(busA), .busB(busB), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic [ADDR_W-1:0] aa;
        logic [ADDR_W-1:0] ba;
        logic              mb;
        logic [DATA_W-1:0] cin;
        logic              stall;
        logic [ADDR_W-1:0] da;
        logic              rw;
        logic              md;
        logic [DATA_W-1:0] f;
        logic [DATA_W-1:0] din;
        logic              fl;
        logic [3:0]        flags;
        logic [DATA_W-1:0] exp_a;
        logic [DATA_W-1:0] exp_b;
        logic [3:0]        exp_s;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic r, input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ba,
        input logic mb, input logic [DATA_W-1:0] cin, input logic st,
        input logic [ADDR_W-1:0] da, input logic rw, input logic md,
        input logic [DATA_W-1:0] f, input logic [DATA_W-1:0] din,
        input logic fl, input logic [3:0] flg,
        input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb, input logic [3:0] es);
        vec_t v;
        v.rst = r; v.aa = aa; v.ba = ba; v.mb = mb; v.cin = cin; v.stall = st;
        v.da = da; v.rw = rw; v.md = md; v.f = f; v.din = din; v.fl = fl; v.flags = flg;
        v.exp_a = ea; v.exp_b = eb; v.exp_s = es;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; AA = v.aa; BA = v.ba; MB = v.mb; const_in = v.cin; stall = v.stall;
        DA = v.da; RW = v.rw; MD = v.md; F_in = v.f; data_in = v.din; FL = v.fl;
        flags_in = v.flags;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        vec_t idle;
        //              rst aa  ba  mb cin            st da  rw md f              din            fl flags    exp_a          exp_b          exp_s
        vecs[0]  = mk(1, 0,  0,  0, 0,             0, 1,  1, 0, 32'hFFFFFFFF, 0,             1, 4'hF,    0,             0,             4'h0);
        vecs[1]  = mk(1, 0,  0,  0, 0,             0, 31, 1, 1, 0,            32'h55555555,  1, 4'hF,    0,             0,             4'h0);
        vecs[2]  = mk(0, 1,  31, 0, 0,             0, 0,  0, 0, 0,            0,             0, 4'h0,    0,             0,             4'h0);
        vecs[3]  = mk(0, 7,  30, 0, 0,             0, 0,  0, 0, 0,            0,             0, 4'h0,    0,             0,             4'h0);
        vecs[4]  = mk(0, 0,  0,  0, 0,             0, 3,  1, 0, 32'hDEADBEEF, 0,             0, 4'h0,    0,             0,             4'h0);
        vecs[5]  = mk(0, 3,  3,  0, 0,             0, 0,  0, 0, 0,            0,             0, 4'h0,    32'hDEADBEEF,  32'hDEADBEEF,  4'h0);
        vecs[6]  = mk(0, 5,  5,  0, 0,             0, 5,  1, 0, 32'h12345678, 0,             0, 4'h0,    32'h12345678,  32'h12345678,  4'h0);
        vecs[7]  = mk(0, 0,  0,  1, 32'h000000A5,  0, 0,  1, 0, 32'hFFFFFFFF, 0,             0, 4'h0,    0,             32'h000000A5,  4'h0);
        vecs[8]  = mk(0, 0,  0,  0, 0,             0, 0,  0, 0, 0,            0,             0, 4'h0,    0,             0,             4'h0);
        vecs[9]  = mk(0, 3,  7,  0, 0,             0, 7,  1, 1, 32'h00001111, 32'hCAFEF00D,  0, 4'h0,    32'hDEADBEEF,  32'hCAFEF00D,  4'h0);
        vecs[10] = mk(0, 7,  5,  0, 0,             0, 0,  0, 0, 0,            0,             0, 4'h0,    32'hCAFEF00D,  32'h12345678,  4'h0);
        vecs[11] = mk(0, 9,  9,  1, 32'h00000077,  0, 9,  1, 0, 32'h00000011, 0,             0, 4'h0,    32'h00000011,  32'h00000077,  4'h0);
        vecs[12] = mk(0, 9,  9,  0, 0,             1, 9,  1, 0, 32'h00000022, 0,             0, 4'h0,    32'h00000011,  32'h00000077,  4'h0);
        vecs[13] = mk(0, 9,  9,  0, 0,             0, 0,  0, 0, 0,            0,             0, 4'h0,    32'h00000022,  32'h00000022,  4'h0);
        vecs[14] = mk(0, 3,  3,  1, 0,             0, 0,  0, 0, 0,            0,             1, 4'b1010, 32'hDEADBEEF,  0,             4'b1010);
        vecs[15] = mk(0, 5,  5,  0, 0,             1, 0,  0, 0, 0,            0,             0, 4'b0101, 32'hDEADBEEF,  0,             4'b1010);
        vecs[16] = mk(0, 7,  7,  0, 0,             1, 0,  0, 0, 0,            0,             1, 4'b0110, 32'hDEADBEEF,  0,             4'b0110);
        vecs[17] = mk(1, 3,  5,  0, 0,             0, 3,  1, 0, 32'h99999999, 0,             1, 4'hF,    0,             0,             4'h0);
        vecs[18] = mk(0, 3,  5,  0, 0,             0, 0,  0, 0, 0,            0,             0, 4'h0,    0,             0,             4'h0);
        vecs[19] = mk(0, 31, 0,  1, 32'hFFFFFFFF,  0, 31, 1, 0, 32'h0000ABCD, 0,             0, 4'h0,    32'h0000ABCD,  32'hFFFFFFFF,  4'h0);
        vecs[20] = mk(0, 31, 31, 0, 0,             0, 31, 1, 1, 32'h0000ABCD, 32'h00000001,  0, 4'h0,    32'h00000001,  32'h00000001,  4'h0);

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 4'h0);
        drive(idle);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check("busA", i, busA, vecs[i].exp_a);
            check("busB", i, busB, vecs[i].exp_b);
            check("status", i, 32'(status), 32'(vecs[i].exp_s));
        end

        // Fill R1..R31 with distinct values, then read every register on both ports.
        for (int i = 1; i < NUM_REGS; i++) begin
            @(negedge clk);
            drive(idle);
            DA = ADDR_W'(i);
            RW = 1'b1;
            F_in = 32'(i) * 32'h01010101 + 32'h100;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            @(negedge clk);
            drive(idle);
            AA = ADDR_W'(i);
            BA = ADDR_W'(NUM_REGS - i);
            @(posedge clk);
            #1;
            check("sweep_busA", i, busA, 32'(i) * 32'h01010101 + 32'h100);
            check("sweep_busB", i, busB, 32'(NUM_REGS - i) * 32'h01010101 + 32'h100);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
